dsp_mem_arbiter: RTL and testbench

Per-cycle arbiter for the DSP's two single-port data memory banks. It sits between the memory stage of the DSP pipeline (core read and write) and the sample loader that writes incoming receiver samples (DMA). It grants each bank to one requester per cycle and stalls the core when its access cannot be served. A starvation guard bounds how long a sample write can wait.

---
 rtl/dsp_mem_arbiter.sv | 113 +++++++++++
 tb/tb_dsp_mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dsp_mem_arbiter.sv
// dsp_mem_arbiter: per-cycle arbiter of core read/write and DMA sample writes onto two single-port banks; DSP_ARB_ANTISTARVE_EN adds the DMA starvation guard
module dsp_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              core_rd_en_i,
    input  logic [ADDR_W-1:0] core_rd_addr_i,
    input  logic              core_wr_en_i,
    input  logic [ADDR_W-1:0] core_wr_addr_i,
    input  logic [DATA_W-1:0] core_wr_data_i,
    output logic              core_stall_o,
    output logic              core_rd_valid_o,
    output logic [DATA_W-1:0] core_rd_data_o,
    input  logic              dma_valid_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_data_i,
    output logic              dma_ready_o,
    output logic              bank1_en_o,
    output logic              bank1_we_o,
    output logic [ADDR_W-2:0] bank1_addr_o,
    output logic [DATA_W-1:0] bank1_wdata_o,
    input  logic [DATA_W-1:0] bank1_rdata_i,
    output logic              bank2_en_o,
    output logic              bank2_we_o,
    output logic [ADDR_W-2:0] bank2_addr_o,
    output logic [DATA_W-1:0] bank2_wdata_o,
    input  logic [DATA_W-1:0] bank2_rdata_i
);
    logic              rd_bank, wr_bank, dma_bank, rd_req, force_dma;
    logic [1:0]        gnt_rd, gnt_wr, gnt_dma;
    logic [ADDR_W-2:0] bank_addr [2];
    logic [DATA_W-1:0] bank_wdata [2];
    logic              read_done_q, read_done_d, rd_sel_q, rd_sel_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign rd_bank  = core_rd_addr_i[ADDR_W-1];
    assign wr_bank  = core_wr_addr_i[ADDR_W-1];
    assign dma_bank = dma_addr_i[ADDR_W-1];
    assign rd_req   = core_rd_en_i & ~read_done_q;

`ifdef DSP_ARB_ANTISTARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;

    assign force_dma = dma_valid_i & (starve_q == SMAX);
    assign starve_d  = (dma_valid_i & ~dma_ready_o) ? ((starve_q == SMAX) ? starve_q : starve_q + SW'(1)) : '0;

    // count consecutive blocked DMA cycles, saturating at the forcing threshold
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign force_dma = 1'b0;
`endif

    // per-bank priority: starved DMA > core read > core write > DMA; nothing granted in reset
    always_comb begin
        gnt_rd  = '0;
        gnt_wr  = '0;
        gnt_dma = '0;
        for (int b = 0; b < 2; b++) begin
            if (rst_n_i) begin
                if (force_dma && dma_bank == 1'(b))          gnt_dma[b] = 1'b1;
                else if (rd_req && rd_bank == 1'(b))         gnt_rd[b]  = 1'b1;
                else if (core_wr_en_i && wr_bank == 1'(b))   gnt_wr[b]  = 1'b1;
                else if (dma_valid_i && dma_bank == 1'(b))   gnt_dma[b] = 1'b1;
            end
            bank_addr[b]  = gnt_rd[b] ? core_rd_addr_i[ADDR_W-2:0] :
                            gnt_wr[b] ? core_wr_addr_i[ADDR_W-2:0] : dma_addr_i[ADDR_W-2:0];
            bank_wdata[b] = gnt_wr[b] ? core_wr_data_i : dma_data_i;
        end
    end

    assign bank1_en_o    = gnt_rd[0] | gnt_wr[0] | gnt_dma[0];
    assign bank1_we_o    = gnt_wr[0] | gnt_dma[0];
    assign bank1_addr_o  = bank_addr[0];
    assign bank1_wdata_o = bank_wdata[0];
    assign bank2_en_o    = gnt_rd[1] | gnt_wr[1] | gnt_dma[1];
    assign bank2_we_o    = gnt_wr[1] | gnt_dma[1];
    assign bank2_addr_o  = bank_addr[1];
    assign bank2_wdata_o = bank_wdata[1];

    assign dma_ready_o  = |gnt_dma;
    assign core_stall_o = rst_n_i & ((rd_req & ~|gnt_rd) | (core_wr_en_i & ~|gnt_wr));

    assign read_done_d = core_stall_o & (read_done_q | |gnt_rd);
    assign rd_valid_d  = |gnt_rd;
    assign rd_sel_d    = |gnt_rd ? rd_bank : rd_sel_q;

    assign core_rd_valid_o = rd_valid_q & rst_n_i;
    assign core_rd_data_o  = core_rd_valid_o ? (rd_sel_q ? bank2_rdata_i : bank1_rdata_i) : rd_data_q;
    assign rd_data_d       = core_rd_data_o;

    // core-side state: held-read flag, read return bank/strobe and last read word
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            read_done_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            read_done_q <= read_done_d;
            rd_sel_q    <= rd_sel_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// tb_dsp_mem_arbiter: table-driven cycle vectors for dsp_mem_arbiter with behavioural bank memories
module tb_dsp_mem_arbiter;
    typedef struct {
        logic        rst_n, re;
        logic [7:0]  ra;
        logic        we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic        dv;
        logic [7:0]  da;
        logic [15:0] dd;
        logic        st, rdy, e1, w1, e2, w2;
        logic [6:0]  a1;
        logic [15:0] wd1;
        logic [6:0]  a2;
        logic [15:0] wd2;
        logic        vld;
        logic [15:0] rdat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, re, we, dv, stall, rvld, rdy, e1, w1, e2, w2;
    logic [7:0]  ra, wa, da;
    logic [15:0] wd, dd, rdata, wd1_o, wd2_o, rd1, rd2;
    logic [6:0]  a1_o, a2_o;
    logic [15:0] mem1 [128];
    logic [15:0] mem2 [128];
    int n_chk = 0, n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dsp_mem_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .core_rd_en_i(re), .core_rd_addr_i(ra),
        .core_wr_en_i(we), .core_wr_addr_i(wa), .core_wr_data_i(wd),
        .core_stall_o(stall), .core_rd_valid_o(rvld), .core_rd_data_o(rdata),
        .dma_valid_i(dv), .dma_addr_i(da), .dma_data_i(dd), .dma_ready_o(rdy),
        .bank1_en_o(e1), .bank1_we_o(w1), .bank1_addr_o(a1_o), .bank1_wdata_o(wd1_o), .bank1_rdata_i(rd1),
        .bank2_en_o(e2), .bank2_we_o(w2), .bank2_addr_o(a2_o), .bank2_wdata_o(wd2_o), .bank2_rdata_i(rd2)
    );

    // read-first single-port bank models, one-cycle read latency
    always @(posedge clk) begin
        if (e1 && !w1) rd1 <= mem1[a1_o];
        if (e1 && w1)  mem1[a1_o] <= wd1_o;
        if (e2 && !w2) rd2 <= mem2[a2_o];
        if (e2 && w2)  mem2[a2_o] <= wd2_o;
    end

    function automatic vec_t mk(input logic r, rq, input logic [7:0] ra_, input logic wq, input logic [7:0] wa_,
                                input logic [15:0] wd_, input logic dq, input logic [7:0] da_, input logic [15:0] dd_,
                                input logic st, rd_, e1_, w1_, e2_, w2_, input logic [6:0] a1_, input logic [15:0] x1,
                                input logic [6:0] a2_, input logic [15:0] x2, input logic vl, input logic [15:0] rt);
        vec_t v;
        v.rst_n = r; v.re = rq; v.ra = ra_; v.we = wq; v.wa = wa_; v.wd = wd_; v.dv = dq; v.da = da_; v.dd = dd_;
        v.st = st; v.rdy = rd_; v.e1 = e1_; v.w1 = w1_; v.e2 = e2_; v.w2 = w2_;
        v.a1 = a1_; v.wd1 = x1; v.a2 = a2_; v.wd2 = x2; v.vld = vl; v.rdat = rt;
        return v;
    endfunction

    function automatic vec_t idle(input logic vl, input logic [15:0] rt);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, vl, rt);
    endfunction

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; re = v.re; ra = v.ra; we = v.we; wa = v.wa; wd = v.wd; dv = v.dv; da = v.da; dd = v.dd;
        #2;
        chk({tag, ".stall"}, 16'(stall), 16'(v.st));
        chk({tag, ".dma_ready"}, 16'(rdy), 16'(v.rdy));
        chk({tag, ".b1_en"}, 16'(e1), 16'(v.e1));
        chk({tag, ".b1_we"}, 16'(w1), 16'(v.w1));
        chk({tag, ".b2_en"}, 16'(e2), 16'(v.e2));
        chk({tag, ".b2_we"}, 16'(w2), 16'(v.w2));
        chk({tag, ".rd_valid"}, 16'(rvld), 16'(v.vld));
        chk({tag, ".rd_data"}, rdata, v.rdat);
        if (v.e1) chk({tag, ".b1_addr"}, 16'(a1_o), 16'(v.a1));
        if (v.w1) chk({tag, ".b1_wdata"}, wd1_o, v.wd1);
        if (v.e2) chk({tag, ".b2_addr"}, 16'(a2_o), 16'(v.a2));
        if (v.w2) chk({tag, ".b2_wdata"}, wd2_o, v.wd2);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem1[i] = 16'h1000 + 16'(i);
            mem2[i] = 16'h2000 + 16'(i);
        end
        rst_n = 0; re = 0; ra = 0; we = 0; wa = 0; wd = 0; dv = 0; da = 0; dd = 0;
        repeat (2) @(posedge clk);
        // reset with requests pending: everything quiet
        vecs.push_back(mk(0, 1, 8'h05, 0, 0, 0, 1, 8'h85, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        // read bank1 + DMA bank2 concurrently
        vecs.push_back(mk(1, 1, 8'h05, 0, 0, 0, 1, 8'h85, 16'h1234, 0, 1, 1, 0, 1, 1, 7'h05, 0, 7'h05, 16'h1234, 0, 16'h0000));
        vecs.push_back(idle(1, 16'h1005));
        // same-bank read + write: two cycles
        vecs.push_back(mk(1, 1, 8'h10, 1, 8'h11, 16'hBEEF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 7'h10, 0, 0, 0, 0, 16'h1005));
        vecs.push_back(mk(1, 1, 8'h10, 1, 8'h11, 16'hBEEF, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'h11, 16'hBEEF, 0, 0, 1, 16'h1010));
        vecs.push_back(idle(0, 16'h1010));
        // DMA write then core read-back
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h30, 16'h00FF, 0, 1, 1, 1, 0, 0, 7'h30, 16'h00FF, 0, 0, 0, 16'h1010));
        vecs.push_back(mk(1, 1, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h30, 0, 0, 0, 0, 16'h1010));
        vecs.push_back(idle(1, 16'h00FF));
        // reset while read_done is set and in the cycle after a read grant
        vecs.push_back(mk(1, 1, 8'h10, 1, 8'h11, 16'hCAFE, 0, 0, 0, 1, 0, 1, 0, 0, 0, 7'h10, 0, 0, 0, 0, 16'h00FF));
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h11, 16'hCAFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00FF));
        vecs.push_back(mk(1, 1, 8'h10, 1, 8'h11, 16'hCAFE, 0, 0, 0, 1, 0, 1, 0, 0, 0, 7'h10, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 8'h10, 1, 8'h11, 16'hCAFE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'h11, 16'hCAFE, 0, 0, 1, 16'h1010));
        vecs.push_back(idle(0, 16'h1010));
        // read bank2, write bank1, DMA bank2 loses to the read
        vecs.push_back(mk(1, 1, 8'h81, 1, 8'h02, 16'h5555, 1, 8'h83, 16'h0ABC, 0, 0, 1, 1, 1, 0, 7'h02, 16'h5555, 7'h01, 0, 0, 16'h1010));
        vecs.push_back(idle(1, 16'h2001));
        vecs.push_back(mk(1, 1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h02, 0, 0, 0, 0, 16'h2001));
        vecs.push_back(idle(1, 16'h5555));
        // core write beats DMA, DMA goes next cycle
        vecs.push_back(mk(1, 0, 0, 1, 8'h40, 16'h0001, 1, 8'h41, 16'h0002, 0, 0, 1, 1, 0, 0, 7'h40, 16'h0001, 0, 0, 0, 16'h5555));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h41, 16'h0002, 0, 1, 1, 1, 0, 0, 7'h41, 16'h0002, 0, 0, 0, 16'h5555));
        // read back the early DMA word from bank2
        vecs.push_back(mk(1, 1, 8'h85, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h05, 0, 0, 16'h5555));
        vecs.push_back(idle(1, 16'h1234));
        for (int i = 0; i < vecs.size(); i++) run($sformatf("r%0d", i), vecs[i]);
        vecs.delete();
        // continuous core reads to bank1 against a DMA write to bank1
`ifdef DSP_ARB_ANTISTARVE_EN
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 1, 8'h20, 16'h7777, 0, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0, k > 1, k > 1 ? 16'h1000 : 16'h1234));
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 1, 8'h20, 16'h7777, 1, 1, 1, 1, 0, 0, 7'h20, 16'h7777, 0, 0, 1, 16'h1000));
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0, 0, 16'h1000));
        vecs.push_back(mk(1, 1, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'h20, 0, 0, 0, 1, 16'h1000));
        vecs.push_back(idle(1, 16'h7777));
`else
        for (int k = 1; k <= 20; k++)
            vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 1, 8'h20, 16'h7777, 0, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0, k > 1, k > 1 ? 16'h1000 : 16'h1234));
        vecs.push_back(idle(1, 16'h1000));
`endif
        for (int i = 0; i < vecs.size(); i++) run($sformatf("starve%0d", i), vecs[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
